// File: rtl/controller_reader.sv
// controller_reader
//
// Reads a serial game pad (latch / shift-clock / serial data protocol) once
// per video frame and presents the eight button states in parallel.
//
// Ports:
//   clk             system clock, all state changes on its rising edge
//   reset           asynchronous active-low reset (0 = in reset)
//   frame_tick      one-cycle pulse per frame requesting a read
//   ctrl_data       serial data from the pad, active-low, asynchronous to clk
//   ctrl_latch      latch strobe to the pad (registered)
//   ctrl_clk        shift clock to the pad (registered)
//   buttons         current button state, active-high
//                   (bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right)
//   buttons_pressed buttons newly pressed in the latest completed read
//   buttons_valid   one-cycle pulse marking an update of buttons/buttons_pressed
//
// Parameter:
//   HALF_PERIOD     clk cycles per half-period of ctrl_clk, legal 4..1023
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for frame_tick, pad lines low
// LATCH    | ctrl_latch high for 2*HALF_PERIOD cycles, bit 0 sampled on exit
// CLK_HI   | ctrl_clk high for HALF_PERIOD cycles, pad shifts on rising edge
// CLK_LO   | ctrl_clk low for HALF_PERIOD cycles, bit[idx] sampled on exit
// DONE     | one cycle, results and buttons_valid visible, back to IDLE

module controller_reader #(
    parameter int HALF_PERIOD = 150
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       ctrl_data,
    output logic       ctrl_latch,
    output logic       ctrl_clk,
    output logic [7:0] buttons,
    output logic [7:0] buttons_pressed,
    output logic       buttons_valid
);

    // 11 bits covers the longest interval, 2*1023 cycles of LATCH.
    localparam int CNT_W = 11;
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        CLK_HI = 3'd2,
        CLK_LO = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       idx_next;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_next;
    logic             load_result;
    logic [1:0]       data_sync;
    logic             data_s;

    // Two-flop synchronizer; resets to the released (1) level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_sync <= 2'b11;
        end else begin
            data_sync <= {data_sync[0], ctrl_data};
        end
    end

    assign data_s = data_sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= next_state;
            cnt       <= cnt_next;
            bit_idx   <= idx_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        next_state  = state;
        cnt_next    = cnt + CNT_W'(1);
        idx_next    = bit_idx;
        shift_next  = shift_reg;
        load_result = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (frame_tick) begin
                    next_state = LATCH;
                    idx_next   = 3'd0;
                end
            end
            LATCH: begin
                if (cnt == LATCH_LAST) begin
                    shift_next[0] = data_s;
                    idx_next      = 3'd1;
                    cnt_next      = '0;
                    next_state    = CLK_HI;
                end
            end
            CLK_HI: begin
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    next_state = CLK_LO;
                end
            end
            CLK_LO: begin
                if (cnt == HALF_LAST) begin
                    shift_next[bit_idx] = data_s;
                    cnt_next            = '0;
                    if (bit_idx == 3'd7) begin
                        next_state  = DONE;
                        load_result = 1'b1;
                    end else begin
                        idx_next   = bit_idx + 3'd1;
                        next_state = CLK_HI;
                    end
                end
            end
            DONE: begin
                // frame_tick is deliberately not looked at here.
                cnt_next   = '0;
                next_state = IDLE;
            end
            default: begin
                cnt_next   = '0;
                next_state = IDLE;
            end
        endcase
    end

    // Pad strobes are registered from the next state so each is high for
    // exactly the cycles its state is occupied, glitch-free and never both.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_latch <= 1'b0;
            ctrl_clk   <= 1'b0;
        end else begin
            ctrl_latch <= (next_state == LATCH);
            ctrl_clk   <= (next_state == CLK_HI);
        end
    end

    // Results are loaded on the edge entering DONE, from the shift value that
    // already includes bit 7, so buttons, buttons_pressed and buttons_valid
    // all appear together during the DONE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buttons         <= '0;
            buttons_pressed <= '0;
            buttons_valid   <= 1'b0;
        end else begin
            buttons_valid <= load_result;
            if (load_result) begin
                buttons         <= ~shift_next;
                buttons_pressed <= ~shift_next & ~buttons;
            end
        end
    end

endmodule

// File: doc/controller_reader.md
CONTROLLER_READER -- requirements
Module: controller_reader

Interface
REQ-001 Parameter HALF_PERIOD, default 150, is the number of clk cycles in one half-period of ctrl_clk (6 us at 25 MHz); legal values are 4 to 1023.
REQ-002 Port clk, input, 1 bit, is the system clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit, is an asynchronous, active-low reset (0 = in reset).
REQ-004 Port frame_tick, input, 1 bit, is a one-cycle pulse per video frame that requests a controller read.
REQ-005 Port ctrl_data, input, 1 bit, is the serial data from the pad; active-low (0 = pressed) and asynchronous to clk.
REQ-006 Port ctrl_latch, output, 1 bit, is the latch strobe to the pad.
REQ-007 Port ctrl_clk, output, 1 bit, is the shift clock to the pad.
REQ-008 Port buttons, output, 8 bits, is the current button state, active-high: bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right; it feeds the character buttons input.
REQ-009 Port buttons_pressed, output, 8 bits, flags buttons newly pressed in the latest completed read.
REQ-010 Port buttons_valid, output, 1 bit, is a one-cycle pulse marking an update of buttons and buttons_pressed.

Function
REQ-011 ctrl_data shall pass through a 2-flop synchronizer, and all samples shall use the synchronized value.
REQ-012 FSM states shall be IDLE, LATCH, CLK_HI, CLK_LO and DONE, with one half-period counter and one 3-bit bit index.
REQ-013 IDLE: ctrl_latch=0 and ctrl_clk=0; frame_tick=1 shall go to LATCH and clear the counter and bit index.
REQ-014 LATCH: ctrl_latch=1 for exactly 2*HALF_PERIOD cycles; the last LATCH cycle shall sample bit 0, then go to CLK_HI with bit index=1.
REQ-015 CLK_HI: ctrl_clk=1 for exactly HALF_PERIOD cycles (the pad shifts on the rising edge), then go to CLK_LO.
REQ-016 CLK_LO: ctrl_clk=0 for exactly HALF_PERIOD cycles; the last cycle shall sample into the bit at the current index.
REQ-017 After CLK_LO, if index=7 the FSM shall go to DONE, otherwise it shall increment the index and go to CLK_HI; this gives exactly 7 ctrl_clk pulses.
REQ-018 DONE lasts one cycle and performs the following updates:
- buttons <= ~shift_reg
- buttons_pressed <= ~shift_reg & ~buttons_old, where buttons_old is the buttons value before this update
- buttons_valid = 1
- next state IDLE
REQ-019 Latency from an accepted frame_tick to buttons_valid shall be exactly 16*HALF_PERIOD+1 cycles.
REQ-020 A frame_tick arriving in any state other than IDLE shall be ignored, not queued.
REQ-021 A frame_tick in the same cycle as DONE shall be ignored; a frame_tick on the first IDLE cycle after DONE shall be accepted.
REQ-022 buttons and buttons_pressed shall hold their values between buttons_valid pulses.
REQ-023 ctrl_latch and ctrl_clk shall be driven directly from registers, with no combinational glitches.
REQ-024 ctrl_latch and ctrl_clk shall never be 1 in the same cycle.

Reset
REQ-025 While reset=0, the block shall be in the following state:
- FSM in IDLE
- counter, index and shift register cleared
- synchronizer flops at 1 (released)
- ctrl_latch=0, ctrl_clk=0
- buttons=0x00, buttons_pressed=0x00, buttons_valid=0
REQ-026 Reset asserted mid-read shall abort the read with no buttons_valid pulse.
REQ-027 After reset, the first read shall report buttons_pressed equal to buttons.

Verification (HALF_PERIOD=4)
REQ-028 Pad model all released (ctrl_data=1 always), one frame_tick -> ctrl_latch high for 8 cycles, then 7 ctrl_clk pulses of 4 high/4 low; buttons_valid exactly 65 cycles after frame_tick; buttons=0x00.
REQ-029 Pad model pressing A and Right (serial sequence 0,1,1,1,1,1,1,0) -> buttons=0x81 and buttons_pressed=0x81; a second identical read -> buttons=0x81 and buttons_pressed=0x00.
REQ-030 Read 1 with Up pressed, read 2 with Up and B pressed -> buttons=0x12 and buttons_pressed=0x02 after read 2.
REQ-031 Extra frame_tick pulses 10 cycles and 40 cycles into a read -> only one buttons_valid pulse and only one latch pulse; a frame_tick coincident with DONE is dropped, and one on the next cycle starts a new latch.
REQ-032 reset=0 applied for 3 cycles during CLK_HI of bit 4 -> outputs return to reset values immediately and no buttons_valid occurs; after release, the next frame_tick completes normally with buttons_pressed equal to buttons.
